// File: rtl/pix_pkg.sv
// Pixel/window constants shared by the windowing stage and the Sobel stage.
package pix_pkg;

  localparam int PIX_W = 8;
  localparam int WIN_W = 9 * PIX_W;

  // Pixel slot of neighbour (r,c) inside a packed 3x3 window; r0 = top, c0 = left.
  function automatic int win_idx(input int r, input int c);
    return 3 * r + c;
  endfunction

endpackage

// File: rtl/window_3x3_gen_if.sv
// AXI-Stream style handshake bundle used for both the pixel input and the window output.
interface window_3x3_gen_if #(
  parameter int DATA_W = 8
);

  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tuser;
  logic              tlast;

  modport master (output tvalid, output tdata, output tuser, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tuser, input tlast, output tready);

endinterface

// File: rtl/line_buffer.sv
// One image line of storage: synchronous write, asynchronous read on the same address.
module line_buffer #(
  parameter int DEPTH = 512,
  parameter int W     = 8
) (
  input  logic                     aclk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem_q [DEPTH];

  // Store the pixel of the current column; contents survive reset and are re-primed by rows 0-1.
  always_ff @(posedge aclk) begin
    if (we) mem_q[addr] <= wdata;
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/window_3x3_gen.sv
// Raster pixel stream in, 3x3 neighbourhood stream out. Two line buffers supply the two rows
// above the incoming pixel; a 3x3 register window shifts left by one column per accepted pixel.
module window_3x3_gen
  import pix_pkg::win_idx;
#(
  parameter int IMG_WIDTH = 512,
  parameter int PIX_W     = pix_pkg::PIX_W
) (
  input  logic                     aclk,
  input  logic                     areset,
  window_3x3_gen_if.slave          s_axis,
  window_3x3_gen_if.master         m_axis,
  output logic                     err_line_len
);

  localparam int                COL_W    = $clog2(IMG_WIDTH);
  localparam int                WIN_W    = 9 * PIX_W;
  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [15:0]       ROW_MAX  = 16'hFFFF;

  logic [COL_W-1:0] col_q, col_d, col_eff;
  logic [15:0]      row_q, row_d, row_eff;
  logic             err_q, err_d;
  logic             m_valid_q, m_valid_d;
  logic             m_user_q, m_user_d;
  logic             m_last_q, m_last_d;
  logic [WIN_W-1:0] m_data_q, m_data_d;

  logic             accept, at_last_col, eol, win_ready;
  logic [PIX_W-1:0] lb0_rd, lb1_rd;
  logic [PIX_W-1:0] win_q [3][3];
  logic [PIX_W-1:0] win_d [3][3];
  logic [WIN_W-1:0] win_flat;

  // Single output register: accept a new pixel whenever it is empty or being drained.
  assign s_axis.tready = !m_valid_q || m_axis.tready;
  assign accept        = s_axis.tvalid && s_axis.tready;

  // Start-of-frame overrides the counters so the tagged pixel lands at (0,0).
  assign col_eff     = s_axis.tuser ? '0 : col_q;
  assign row_eff     = s_axis.tuser ? '0 : row_q;
  assign at_last_col = (col_eff == LAST_COL);
  assign eol         = at_last_col || s_axis.tlast;
  assign win_ready   = (row_eff >= 16'd2) && (col_eff >= COL_W'(2));

  // lb0 holds row-1, lb1 holds row-2; each accepted pixel pushes the column down one line.
  line_buffer #(.DEPTH(IMG_WIDTH), .W(PIX_W)) u_lb0 (
    .aclk  (aclk),
    .we    (accept),
    .addr  (col_eff),
    .wdata (s_axis.tdata),
    .rdata (lb0_rd)
  );

  line_buffer #(.DEPTH(IMG_WIDTH), .W(PIX_W)) u_lb1 (
    .aclk  (aclk),
    .we    (accept),
    .addr  (col_eff),
    .wdata (lb0_rd),
    .rdata (lb1_rd)
  );

  // Window after this pixel: old columns 1,2 move left, new right column is {row-2, row-1, row}.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_d[r][0] = win_q[r][1];
      win_d[r][1] = win_q[r][2];
    end
    win_d[0][2] = lb1_rd;
    win_d[1][2] = lb0_rd;
    win_d[2][2] = s_axis.tdata;
  end

  for (genvar gi = 0; gi < 9; gi++) begin : g_pack
    assign win_flat[win_idx(gi / 3, gi % 3) * PIX_W +: PIX_W] = win_d[gi / 3][gi % 3];
  end

  // Window registers carry no reset: they only matter once two fresh rows have been seen.
  always_ff @(posedge aclk) begin
    if (accept) win_q <= win_d;
  end

  // Next state for counters, error flag and the output register.
  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    err_d     = err_q;
    m_valid_d = m_valid_q;
    m_user_d  = m_user_q;
    m_last_d  = m_last_q;
    m_data_d  = m_data_q;
    if (accept) begin
      if (eol) begin
        col_d = '0;
        row_d = (row_eff == ROW_MAX) ? row_eff : row_eff + 16'd1;
      end else begin
        col_d = col_eff + COL_W'(1);
        row_d = row_eff;
      end
      if (s_axis.tlast != at_last_col) err_d = 1'b1;
    end
    if (accept && win_ready) begin
      m_valid_d = 1'b1;
      m_user_d  = (row_eff == 16'd2) && (col_eff == COL_W'(2));
      m_last_d  = eol;
      m_data_d  = win_flat;
    end else if (m_axis.tready) begin
      m_valid_d = 1'b0;
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      col_q     <= '0;
      row_q     <= '0;
      err_q     <= 1'b0;
      m_valid_q <= 1'b0;
      m_user_q  <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      err_q     <= err_d;
      m_valid_q <= m_valid_d;
      m_user_q  <= m_user_d;
      m_last_q  <= m_last_d;
      m_data_q  <= m_data_d;
    end
  end

  assign m_axis.tvalid = m_valid_q;
  assign m_axis.tuser  = m_user_q;
  assign m_axis.tlast  = m_last_q;
  assign m_axis.tdata  = m_data_q;
  assign err_line_len  = err_q;

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed bench for window_3x3_gen with an 8-pixel line width and a ramp image 8*row+col.
module tb_window_3x3_gen;

  logic clk    = 1'b0;
  logic areset = 1'b1;
  logic err;
  int   rdy_mode = 0;  // 0: m_tready=1, 1: toggle 1010..., 2: m_tready=0

  window_3x3_gen_if #(.DATA_W(8))  s_if ();
  window_3x3_gen_if #(.DATA_W(72)) m_if ();

  window_3x3_gen #(.IMG_WIDTH(8), .PIX_W(8)) dut (
    .aclk         (clk),
    .areset       (areset),
    .s_axis       (s_if),
    .m_axis       (m_if),
    .err_line_len (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_passed = 0;
  int cyc = 0;
  int rule_viol = 0;
  int hold_viol = 0;
  int acc_last = 0;
  logic [73:0] cap_q[$];
  int          cap_cyc[$];
  int          acc_q[$];
  logic        prev_stall = 1'b0;
  logic [73:0] prev_word = '0;

  task automatic check(input string tag, input logic [73:0] got, input logic [73:0] exp);
    n_checks++;
    if (got === exp) n_passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Expected ramp window number idx (row-major over output positions), as {tuser, tlast, tdata}.
  function automatic logic [73:0] exp_win(input int idx);
    logic [71:0] d;
    int r, c;
    r = idx / 6 + 2;
    c = idx % 6 + 2;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        d[(3 * dr + dc) * 8 +: 8] = 8'(8 * (r - 2 + dr) + (c - 2 + dc));
    return {(r == 2 && c == 2), (c == 7), d};
  endfunction

  // Downstream ready generator.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1:       m_if.tready = ~m_if.tready;
      2:       m_if.tready = 1'b0;
      default: m_if.tready = 1'b1;
    endcase
  end

  // Monitor: capture handshakes and watch the ready rule and output stability.
  always @(negedge clk) begin
    cyc++;
    if (!areset) begin
      if (s_if.tready !== (!m_if.tvalid || m_if.tready)) rule_viol++;
      if (prev_stall && (!m_if.tvalid || {m_if.tuser, m_if.tlast, m_if.tdata} !== prev_word))
        hold_viol++;
      if (m_if.tvalid && m_if.tready) begin
        cap_q.push_back({m_if.tuser, m_if.tlast, m_if.tdata});
        cap_cyc.push_back(cyc);
        $display("win cyc=%0d user=%0b last=%0b data=%h", cyc, m_if.tuser, m_if.tlast, m_if.tdata);
      end
    end
    prev_stall = m_if.tvalid && !m_if.tready && !areset;
    prev_word  = {m_if.tuser, m_if.tlast, m_if.tdata};
  end

  task automatic send_pixel(input logic [7:0] d, input logic u, input logic l);
    int guard;
    guard = 0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = d;
    s_if.tuser  = u;
    s_if.tlast  = l;
    while (1) begin
      @(negedge clk);
      if (s_if.tready) break;
      guard++;
      if (guard > 200) begin
        check("accept_timeout", 74'd0, 74'd1);
        break;
      end
    end
    @(posedge clk);
    acc_last = cyc;
    #1;
    s_if.tvalid = 1'b0;
    s_if.tuser  = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic send_frame(input int gap);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++) begin
        send_pixel(8'(8 * r + c), (r == 0 && c == 0), (c == 7));
        if (r >= 2 && c >= 2) acc_q.push_back(acc_last);
        if (gap > 0) begin
          repeat (gap) @(posedge clk);
          #1;
        end
      end
  endtask

  task automatic clear_caps();
    cap_q.delete();
    cap_cyc.delete();
    acc_q.delete();
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic check_ramp(input string tname, input int base);
    logic [73:0] got;
    for (int i = 0; i < 12; i++) begin
      got = (base + i < cap_q.size()) ? cap_q[base + i] : '0;
      check($sformatf("%s_win%0d", tname, i), got, exp_win(i));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tuser  = 1'b0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", 74'(m_if.tvalid), 74'd0);
    check("rst_tdata",  74'(m_if.tdata),  74'd0);
    check("rst_tuser",  74'(m_if.tuser),  74'd0);
    check("rst_tlast",  74'(m_if.tlast),  74'd0);
    check("rst_err",    74'(err),         74'd0);
    check("rst_sready", 74'(s_if.tready), 74'd1);
    @(posedge clk);
    #1 areset = 1'b0;

    // Test 1: ramp frame, tready=1
    clear_caps();
    send_frame(0);
    drain();
    check("t1_count", 74'(cap_q.size()), 74'd12);
    check_ramp("t1", 0);
    check("t1_err", 74'(err), 74'd0);

    // Test 2: downstream ready toggling
    clear_caps();
    rdy_mode = 1;
    send_frame(0);
    drain();
    rdy_mode = 0;
    drain();
    check("t2_count", 74'(cap_q.size()), 74'd12);
    check_ramp("t2", 0);

    // Test 6: input gaps, one cycle latency from accept
    clear_caps();
    send_frame(2);
    drain();
    check("t6_count", 74'(cap_q.size()), 74'd12);
    check_ramp("t6", 0);
    for (int i = 0; i < 12; i++) begin
      if (i < cap_cyc.size() && i < acc_q.size())
        check($sformatf("t6_lat%0d", i), 74'(cap_cyc[i] - acc_q[i]), 74'd1);
      else
        check($sformatf("t6_lat%0d", i), 74'd0, 74'd1);
    end

    // Test 3: short line (tlast at col 5 of row 1)
    clear_caps();
    for (int c = 0; c < 8; c++) send_pixel(8'(c), (c == 0), (c == 7));
    for (int c = 0; c < 5; c++) send_pixel(8'(8 + c), 1'b0, 1'b0);
    check("t3_err_before", 74'(err), 74'd0);
    send_pixel(8'(13), 1'b0, 1'b1);
    check("t3_err_after", 74'(err), 74'd1);
    for (int c = 0; c < 8; c++) send_pixel(8'(16 + c), 1'b0, (c == 7));
    drain();
    check("t3_count", 74'(cap_q.size()), 74'd6);
    check("t3_first", (cap_q.size() > 0) ? cap_q[0] : 74'd0, exp_win(0));
    check("t3_last_flags", (cap_q.size() > 5) ? 74'(cap_q[5][73:72]) : 74'd0, 74'd1);
    check("t3_err_sticky", 74'(err), 74'd1);

    // Test 5: reset mid-line while the output is stalled
    clear_caps();
    rdy_mode = 2;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 8; c++)
        if (r < 2 || c < 3) send_pixel(8'(8 * r + c), (r == 0 && c == 0), (c == 7));
    check("t5_stalled", 74'(m_if.tvalid), 74'd1);
    @(posedge clk);
    #2 areset = 1'b1;
    #1;
    check("t5_async_tvalid", 74'(m_if.tvalid), 74'd0);
    check("t5_async_err",    74'(err),         74'd0);
    check("t5_async_tdata",  74'(m_if.tdata),  74'd0);
    @(posedge clk);
    #1 areset = 1'b0;
    rdy_mode = 0;
    clear_caps();
    send_frame(0);
    drain();
    check("t5_count", 74'(cap_q.size()), 74'd12);
    check_ramp("t5", 0);

    // Test 4: tuser mid-frame at (3,4) restarts the counters
    clear_caps();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++)
        if (r < 3 || c < 4) send_pixel(8'(8 * r + c), (r == 0 && c == 0), (c == 7));
    send_frame(0);
    drain();
    check("t4_count", 74'(cap_q.size()), 74'd20);
    for (int i = 0; i < 20; i++)
      check($sformatf("t4_win%0d", i), (i < cap_q.size()) ? cap_q[i] : 74'd0,
            exp_win((i < 8) ? i : i - 8));

    check("ready_rule", 74'(rule_viol), 74'd0);
    check("stall_hold", 74'(hold_viol), 74'd0);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
